tcs_scan_controller: RTL

Sequences the TCS3200 colour sensor through one full measurement scan.
- Drives the `filter` select lines through the green, red and blue phases.
- Counts `cs_out` rising edges in a fixed window per phase.
- Picks the dominant colour and hands one result byte to the UART transmitter through a level handshake.
- Sits between the sensor pins and the UART TX block, in the clk_1MHz domain.

---
 rtl/tcs_scan_controller.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/tcs_scan_controller.sv
// TCS3200 scan sequencer: steps the filter through green/red/blue, counts cs_out edges per window,
// and hands the dominant colour byte to the UART. Define TCS_SCAN_RAW_COUNT_EN to also send the raw counts.
module tcs_scan_controller #(
    parameter int WINDOW_CYCLES = 500,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16,
    parameter int MIN_COUNT     = 4
) (
    input  logic       clk_1MHz,
    input  logic       reset,
    input  logic       cs_out,
    input  logic       run,
    input  logic       tx_busy,
    output logic [1:0] filter,
    output logic [1:0] color,
    output logic       color_valid,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       scan_active
);
    localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_COUNT);

    localparam logic [1:0] F_GREEN = 2'd3;
    localparam logic [1:0] F_RED   = 2'd0;
    localparam logic [1:0] F_BLUE  = 2'd1;
    localparam logic [1:0] F_CLEAR = 2'd2;
    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_RED   = 2'd1;
    localparam logic [1:0] C_GREEN = 2'd2;
    localparam logic [1:0] C_BLUE  = 2'd3;

    typedef enum logic [3:0] {
        IDLE, SET_G, CNT_G, SET_R, CNT_R, SET_B, CNT_B, DECIDE, SEND, WAIT_TX
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_g_q, cnt_g_d, cnt_r_q, cnt_r_d, cnt_b_q, cnt_b_d;
    logic             cs_meta_q, cs_sync_q, cs_prev_q, busy_prev_q;
    logic             cs_rise, last_byte;
    logic [1:0]       filter_q, filter_d, color_q, color_d;
    logic             color_valid_q, color_valid_d;
    logic             tx_start_q, tx_start_d;
    logic             scan_active_q, scan_active_d;
    logic [7:0]       tx_data_q, tx_data_d;
`ifdef TCS_SCAN_RAW_COUNT_EN
    logic [2:0]       byte_idx_q, byte_idx_d;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [1:0] pick_color(input logic [CNT_W-1:0] r,
                                              input logic [CNT_W-1:0] g,
                                              input logic [CNT_W-1:0] b);
        logic [CNT_W-1:0] mx;
        mx = r;
        if (g > mx) mx = g;
        if (b > mx) mx = b;
        if (mx < MIN_CNT) return C_NONE;
        // Ties resolve red first, then green, then blue.
        if (r == mx) return C_RED;
        if (g == mx) return C_GREEN;
        return C_BLUE;
    endfunction

    function automatic logic [7:0] color_ascii(input logic [1:0] c);
        case (c)
            C_RED:   return 8'h52;
            C_GREEN: return 8'h47;
            C_BLUE:  return 8'h42;
            default: return 8'h4E;
        endcase
    endfunction

`ifdef TCS_SCAN_RAW_COUNT_EN
    function automatic logic [15:0] to16(input logic [CNT_W-1:0] v);
        logic [CNT_W+15:0] ext;
        ext = {16'h0000, v};
        return ext[15:0];
    endfunction

    assign last_byte = (byte_idx_q == 3'd6);
`else
    assign last_byte = 1'b1;
`endif

    assign cs_rise = cs_sync_q & ~cs_prev_q;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + TMR_W'(1);
        cnt_g_d = cnt_g_q;
        cnt_r_d = cnt_r_q;
        cnt_b_d = cnt_b_q;
        case (state_q)
            IDLE:    if (run) state_d = SET_G;
            SET_G: begin
                cnt_g_d = '0;
                if (tmr_q == SETTLE_LAST) state_d = CNT_G;
            end
            CNT_G: begin
                if (cs_rise) cnt_g_d = sat_inc(cnt_g_q);
                if (tmr_q == WIN_LAST) state_d = SET_R;
            end
            SET_R: begin
                cnt_r_d = '0;
                if (tmr_q == SETTLE_LAST) state_d = CNT_R;
            end
            CNT_R: begin
                if (cs_rise) cnt_r_d = sat_inc(cnt_r_q);
                if (tmr_q == WIN_LAST) state_d = SET_B;
            end
            SET_B: begin
                cnt_b_d = '0;
                if (tmr_q == SETTLE_LAST) state_d = CNT_B;
            end
            CNT_B: begin
                if (cs_rise) cnt_b_d = sat_inc(cnt_b_q);
                if (tmr_q == WIN_LAST) state_d = DECIDE;
            end
            DECIDE:  state_d = SEND;
            // Only a fresh 0->1 of tx_busy acknowledges the request, never a level left over.
            SEND:    if (tx_busy && !busy_prev_q) state_d = WAIT_TX;
            WAIT_TX: begin
                if (!tx_busy) begin
                    if (!last_byte) state_d = SEND;
                    else if (run)   state_d = SET_G;
                    else            state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) tmr_d = '0;

`ifdef TCS_SCAN_RAW_COUNT_EN
        byte_idx_d = byte_idx_q;
        if (state_q == DECIDE)                            byte_idx_d = '0;
        else if (state_q == WAIT_TX && state_d == SEND)   byte_idx_d = byte_idx_q + 3'd1;
`endif

        // Outputs are decoded from the next state so they move on the same edge as the FSM.
        case (state_d)
            SET_G, CNT_G: filter_d = F_GREEN;
            SET_R, CNT_R: filter_d = F_RED;
            SET_B, CNT_B: filter_d = F_BLUE;
            default:      filter_d = F_CLEAR;
        endcase
        scan_active_d = (state_d != IDLE);
        color_valid_d = (state_d == DECIDE);
        color_d       = (state_d == DECIDE) ? pick_color(cnt_r_d, cnt_g_d, cnt_b_d) : color_q;
        tx_start_d    = (state_d == SEND);
        tx_data_d     = tx_data_q;
        if (state_d == SEND && state_q != SEND) begin
`ifdef TCS_SCAN_RAW_COUNT_EN
            case (byte_idx_d)
                3'd1:    tx_data_d = to16(cnt_r_q)[15:8];
                3'd2:    tx_data_d = to16(cnt_r_q)[7:0];
                3'd3:    tx_data_d = to16(cnt_g_q)[15:8];
                3'd4:    tx_data_d = to16(cnt_g_q)[7:0];
                3'd5:    tx_data_d = to16(cnt_b_q)[15:8];
                3'd6:    tx_data_d = to16(cnt_b_q)[7:0];
                default: tx_data_d = color_ascii(color_q);
            endcase
`else
            tx_data_d = color_ascii(color_q);
`endif
        end
    end

    always_ff @(posedge clk_1MHz or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            tmr_q         <= '0;
            cnt_g_q       <= '0;
            cnt_r_q       <= '0;
            cnt_b_q       <= '0;
            cs_meta_q     <= 1'b0;
            cs_sync_q     <= 1'b0;
            cs_prev_q     <= 1'b0;
            busy_prev_q   <= 1'b0;
            filter_q      <= F_CLEAR;
            color_q       <= C_NONE;
            color_valid_q <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            scan_active_q <= 1'b0;
`ifdef TCS_SCAN_RAW_COUNT_EN
            byte_idx_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            cnt_g_q       <= cnt_g_d;
            cnt_r_q       <= cnt_r_d;
            cnt_b_q       <= cnt_b_d;
            cs_meta_q     <= cs_out;
            cs_sync_q     <= cs_meta_q;
            cs_prev_q     <= cs_sync_q;
            busy_prev_q   <= tx_busy;
            filter_q      <= filter_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            scan_active_q <= scan_active_d;
`ifdef TCS_SCAN_RAW_COUNT_EN
            byte_idx_q    <= byte_idx_d;
`endif
        end
    end

    assign filter      = filter_q;
    assign color       = color_q;
    assign color_valid = color_valid_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign scan_active = scan_active_q;
endmodule
